mole_scheduler: RTL
===================

# mole_scheduler

Round controller for the whack-a-mole game. It sequences the nine mole LEDs through a fixed number of rounds and picks each mole position from a free-running LFSR. It times each mole's up-window, checks debounced pushbutton presses against the lit mole, and emits one-cycle hit/miss pulses to the score counter and HEX display logic. It sits between the button debouncers and the LEDR/score datapath and replaces the ad-hoc LED timing in the top level.

## Interface
Parameters:
- UP_TICKS, 100000000, cycles a mole stays lit with no hit (2 s at 50 MHz)
- GAP_TICKS, 25000000, dark cycles between moles
- ROUNDS, 30, moles per game; legal range 1..99
- STEP_TICKS, 5000000, up-window reduction per hit (speedup only)
- MIN_UP_TICKS, 25000000, floor for up-window (speedup only)

Ports:
- cin  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- start  input  1  one-cycle request to begin a game
- btn  input  9  debounced pushbuttons, active-high level
- mole  output  9  one-hot lit mole (drives LEDR[8:0]); 0 when none
- hit  output  1  one-cycle pulse on a correct press
- miss  output  1  one-cycle pulse on window expiry
- round  output  7  completed rounds, 0..ROUNDS
- busy  output  1  high in GAP/UP
- done  output  1  high in DONE

## Operation
- Reset values: state IDLE; mole=0, hit=0, miss=0, round=0, busy=0, done=0, lfsr=8'h01, btn_q=0, prev_pos=0, up_len=UP_TICKS.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifts every cycle in every state, never 0.
- Edge detect: btn_q registers btn every cycle; rise = btn & ~btn_q.
- IDLE: start -> GAP; load gap counter; round=0; up_len=UP_TICKS.
- GAP: counter counts down; on terminal count -> UP. Entering UP sets pos = lfsr % 9. If pos == prev_pos, use (pos+1) % 9 instead. Then set mole = 1<<pos, load up counter with up_len, and prev_pos = pos.
- UP, rise[pos]=1: hit=1 for one cycle, mole=0, round+1. Next state is DONE if the new round == ROUNDS, else GAP.
- UP, up counter terminal: miss=1 for one cycle, mole=0, round+1. Next state follows the same rule.
- UP, rise on another bit: ignored; no penalty.
- A button already held when the mole lights does not score. A new rising edge is required.
- Same cycle hit edge and terminal count: hit wins, no miss.
- DONE: mole=0, done=1. start -> GAP exactly as from IDLE.
- start in GAP/UP: ignored.
- rst at any time: immediate return to reset values, including mid-window. The mole is extinguished with no hit/miss pulse.
- Widths: gap/up counters 32 bits; up_len 32 bits; round 7 bits.

## Timing
- start sampled high at edge N: busy=1 from N+1.
- The first mole lights at edge N+1+GAP_TICKS.
- An unhit mole stays lit exactly up_len cycles. miss is asserted during the cycle after the last lit cycle, and mole=0 in that same cycle.
- btn rising at the input before edge M: at M, hit=1 and mole=0 (registered, one-cycle latency).
- Each GAP lasts exactly GAP_TICKS cycles with mole=0.
- done rises in the same cycle as the final hit/miss pulse.
- round updates in the same cycle as its hit/miss pulse.

## Configuration
- MOLE_SPEEDUP_EN defined: each hit sets up_len = max(up_len − STEP_TICKS, MIN_UP_TICKS), computed without underflow. Misses leave up_len unchanged. up_len reloads to UP_TICKS on start.
- Not defined: up_len is constant UP_TICKS. STEP_TICKS and MIN_UP_TICKS are unused.

## Test plan
Parameters for all scenarios: UP_TICKS=20, GAP_TICKS=5, ROUNDS=3, STEP_TICKS=4, MIN_UP_TICKS=12.

- No presses after start: the mole lights 5 cycles after busy. Each mole is lit 20 cycles. There are 3 miss pulses spaced 25 cycles apart, and done=1 with round=3 on the third.
- Press the lit bit 3 cycles after lighting: hit pulse next edge, mole=0, round=1, and a 5-cycle gap follows. Pressing a wrong bit gives no hit, and miss arrives at cycle 20.
- Hold the correct button before the mole lights: no hit. Release then press again: hit.
- Press edge lands on the terminal-count cycle: hit=1, miss stays 0.
- MOLE_SPEEDUP_EN with 3 consecutive hits: up_len goes 20→16→12→12.
  - Check the later windows by letting moles time out: 16 then 12 cycles.
  - Without the macro, all windows are 20.
- rst asserted mid-UP: mole=0 and busy=0 immediately, no pulses. start pulsed in UP is ignored. Consecutive moles never repeat a position across 50 rounds (ROUNDS=99).

Source files
------------

// File: rtl/mole_scheduler.sv
// mole_scheduler
//   Round controller for the whack-a-mole game. Lights one of nine moles per
//   round at a position drawn from a free-running 8-bit LFSR, times the
//   up-window, scores debounced button presses against the lit mole and emits
//   one-cycle hit/miss pulses for the score/HEX datapath.
//
//   Optional feature macro: MOLE_SPEEDUP_EN
//     defined   - every hit shortens the up-window by STEP_TICKS, with a
//                 floor of MIN_UP_TICKS; the window reloads to UP_TICKS on start
//     undefined - the up-window is fixed at UP_TICKS
//
// Ports
//   cin    in   1  clock
//   rst    in   1  asynchronous active-high reset
//   start  in   1  one-cycle request to begin a game (ignored while busy)
//   btn    in   9  debounced pushbuttons, active-high level
//   mole   out  9  one-hot lit mole, 0 when none
//   hit    out  1  one-cycle pulse on a correct press
//   miss   out  1  one-cycle pulse when the up-window expires
//   round  out  7  completed rounds, 0..ROUNDS
//   busy   out  1  high while a game is running (gap or up phase)
//   done   out  1  high after the final round until the next start
module mole_scheduler #(
    parameter int unsigned UP_TICKS     = 100000000,
    parameter int unsigned GAP_TICKS    = 25000000,
    parameter int unsigned ROUNDS       = 30,
    parameter int unsigned STEP_TICKS   = 5000000,
    parameter int unsigned MIN_UP_TICKS = 25000000
) (
    input  logic       cin,
    input  logic       rst,
    input  logic       start,
    input  logic [8:0] btn,
    output logic [8:0] mole,
    output logic       hit,
    output logic       miss,
    output logic [6:0] round,
    output logic       busy,
    output logic       done
);

`ifdef MOLE_SPEEDUP_EN
    localparam bit LP_SPEEDUP = 1'b1;
`else
    localparam bit LP_SPEEDUP = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_GAP, S_UP, S_DONE} state_t;

    state_t      r_state, w_state_n;
    logic [31:0] r_cnt, w_cnt_n;
    logic [31:0] r_up_len, w_up_len_n;
    logic [7:0]  r_lfsr;
    logic [8:0]  r_btn_q;
    logic [3:0]  r_prev_pos, w_prev_pos_n;
    logic [8:0]  r_mole, w_mole_n;
    logic        r_hit, w_hit_n;
    logic        r_miss, w_miss_n;
    logic [6:0]  r_round, w_round_n;

    logic [8:0]  w_rise;
    logic [3:0]  w_pos_raw;
    logic [3:0]  w_pos;
    logic [32:0] w_floor_sum;
    logic [31:0] w_up_len_dec;
    logic        w_end;

    assign w_rise    = btn & ~r_btn_q;
    assign w_pos_raw = 4'(r_lfsr % 8'd9);
    // Never repeat the previous position: bump to the next slot, wrapping 8 -> 0.
    assign w_pos     = (w_pos_raw != r_prev_pos) ? w_pos_raw :
                       ((w_pos_raw == 4'd8) ? 4'd0 : w_pos_raw + 4'd1);

    // Shortened window, clamped at the floor; compared at 33 bits so neither
    // the subtraction nor MIN+STEP can wrap.
    assign w_floor_sum  = 33'(MIN_UP_TICKS) + 33'(STEP_TICKS);
    assign w_up_len_dec = ({1'b0, r_up_len} >= w_floor_sum) ? (r_up_len - STEP_TICKS)
                                                           : MIN_UP_TICKS;

    always_ff @(posedge cin or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_up_len   <= UP_TICKS;
            r_lfsr     <= 8'h01;
            r_btn_q    <= '0;
            r_prev_pos <= '0;
            r_mole     <= '0;
            r_hit      <= 1'b0;
            r_miss     <= 1'b0;
            r_round    <= '0;
        end else begin
            r_state    <= w_state_n;
            r_cnt      <= w_cnt_n;
            r_up_len   <= w_up_len_n;
            r_lfsr     <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
            r_btn_q    <= btn;
            r_prev_pos <= w_prev_pos_n;
            r_mole     <= w_mole_n;
            r_hit      <= w_hit_n;
            r_miss     <= w_miss_n;
            r_round    <= w_round_n;
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_cnt_n      = r_cnt;
        w_up_len_n   = r_up_len;
        w_prev_pos_n = r_prev_pos;
        w_mole_n     = r_mole;
        w_hit_n      = 1'b0;
        w_miss_n     = 1'b0;
        w_round_n    = r_round;
        w_end        = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_n  = S_GAP;
                    w_cnt_n    = GAP_TICKS - 1;
                    w_round_n  = '0;
                    w_up_len_n = UP_TICKS;
                    w_mole_n   = '0;
                end
            end
            S_GAP: begin
                if (r_cnt == '0) begin
                    w_state_n    = S_UP;
                    w_cnt_n      = r_up_len - 1;
                    w_mole_n     = 9'd1 << w_pos;
                    w_prev_pos_n = w_pos;
                end else begin
                    w_cnt_n = r_cnt - 1;
                end
            end
            S_UP: begin
                // The lit mole is one-hot, so masking the rise vector with it
                // selects the edge on the lit position; a hit beats expiry.
                if (|(w_rise & r_mole)) begin
                    w_hit_n = 1'b1;
                    w_end   = 1'b1;
                    if (LP_SPEEDUP) begin
                        w_up_len_n = w_up_len_dec;
                    end
                end else if (r_cnt == '0) begin
                    w_miss_n = 1'b1;
                    w_end    = 1'b1;
                end else begin
                    w_cnt_n = r_cnt - 1;
                end

                if (w_end) begin
                    w_mole_n  = '0;
                    w_round_n = r_round + 7'd1;
                    if (w_round_n == 7'(ROUNDS)) begin
                        w_state_n = S_DONE;
                    end else begin
                        w_state_n = S_GAP;
                        w_cnt_n   = GAP_TICKS - 1;
                    end
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    assign mole  = r_mole;
    assign hit   = r_hit;
    assign miss  = r_miss;
    assign round = r_round;
    assign busy  = (r_state == S_GAP) || (r_state == S_UP);
    assign done  = (r_state == S_DONE);

endmodule
